// File: rtl/load_store_unit.sv
// Load/store unit between a CPU request port and a single-ported word memory.
// Sub-word stores use read-modify-write; bad size, misalignment or out-of-range addresses fault.
//
//   state | meaning
//   IDLE  | req_ready high, waiting for a request
//   READ  | mem_memr cycle, memory word sampled at end of cycle
//   WRITE | mem_memw cycle with merged or full store word
//   RESP  | one-cycle rsp_valid pulse
module load_store_unit #(
    parameter logic [31:0] DMEM_BASE_ADDR = 32'h1000,
    parameter int          DMEM_WORDS     = 1024
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_we,
    input  logic [1:0]  req_size,
    input  logic        req_unsigned,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    output logic        rsp_valid,
    output logic [31:0] rsp_rdata,
    output logic        rsp_fault,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_wdata,
    output logic        mem_memr,
    output logic        mem_memw,
    input  logic [31:0] mem_rdata
);

    typedef enum logic [1:0] {IDLE, READ, WRITE, RESP} state_t;

    // 33-bit bounds so the end of a memory placed at the top of the map cannot wrap
    localparam logic [32:0] DMEM_LO = {1'b0, DMEM_BASE_ADDR};
    localparam logic [32:0] DMEM_HI = DMEM_LO + (33'(DMEM_WORDS) * 33'd4);

    state_t      state;
    logic        cap_we;
    logic [1:0]  cap_size;
    logic        cap_unsigned;
    logic [31:0] cap_addr;
    logic [31:0] cap_wdata;

    logic        req_fault;
    logic [7:0]  lane_b;
    logic [15:0] lane_h;
    logic [31:0] load_data;
    logic [31:0] merge_data;

    always_comb begin
        req_fault = (req_size == 2'b11)
                  | ((req_size == 2'b01) & req_addr[0])
                  | ((req_size == 2'b10) & (req_addr[1:0] != 2'b00))
                  | ({1'b0, req_addr} < DMEM_LO)
                  | ({1'b0, req_addr} >= DMEM_HI);
    end

    always_comb begin
        case (cap_addr[1:0])
            2'd0:    lane_b = mem_rdata[7:0];
            2'd1:    lane_b = mem_rdata[15:8];
            2'd2:    lane_b = mem_rdata[23:16];
            default: lane_b = mem_rdata[31:24];
        endcase
        lane_h = cap_addr[1] ? mem_rdata[31:16] : mem_rdata[15:0];
        case (cap_size)
            2'b00:   load_data = {{24{~cap_unsigned & lane_b[7]}}, lane_b};
            2'b01:   load_data = {{16{~cap_unsigned & lane_h[15]}}, lane_h};
            default: load_data = mem_rdata;
        endcase
    end

    always_comb begin
        merge_data = mem_rdata;
        if (cap_size == 2'b00) begin
            case (cap_addr[1:0])
                2'd0:    merge_data[7:0]   = cap_wdata[7:0];
                2'd1:    merge_data[15:8]  = cap_wdata[7:0];
                2'd2:    merge_data[23:16] = cap_wdata[7:0];
                default: merge_data[31:24] = cap_wdata[7:0];
            endcase
        end else if (cap_addr[1]) begin
            merge_data[31:16] = cap_wdata[15:0];
        end else begin
            merge_data[15:0] = cap_wdata[15:0];
        end
    end

    // Outputs are registered alongside the state, so each one is set on entry to its state
    always_ff @(posedge clk) begin
        if (reset) begin
            state        <= IDLE;
            cap_we       <= 1'b0;
            cap_size     <= 2'b00;
            cap_unsigned <= 1'b0;
            cap_addr     <= 32'd0;
            cap_wdata    <= 32'd0;
            req_ready    <= 1'b1;
            rsp_valid    <= 1'b0;
            rsp_rdata    <= 32'd0;
            rsp_fault    <= 1'b0;
            mem_addr     <= 32'd0;
            mem_wdata    <= 32'd0;
            mem_memr     <= 1'b0;
            mem_memw     <= 1'b0;
        end else begin
            rsp_valid <= 1'b0;
            mem_memr  <= 1'b0;
            mem_memw  <= 1'b0;
            mem_addr  <= 32'd0;
            mem_wdata <= 32'd0;
            case (state)
                IDLE: begin
                    if (req_valid) begin
                        cap_we       <= req_we;
                        cap_size     <= req_size;
                        cap_unsigned <= req_unsigned;
                        cap_addr     <= req_addr;
                        cap_wdata    <= req_wdata;
                        req_ready    <= 1'b0;
                        if (req_fault) begin
                            state     <= RESP;
                            rsp_valid <= 1'b1;
                            rsp_rdata <= 32'd0;
                            rsp_fault <= 1'b1;
                        end else if (!req_we || (req_size != 2'b10)) begin
                            state    <= READ;
                            mem_memr <= 1'b1;
                            mem_addr <= {req_addr[31:2], 2'b00};
                        end else begin
                            state     <= WRITE;
                            mem_memw  <= 1'b1;
                            mem_addr  <= {req_addr[31:2], 2'b00};
                            mem_wdata <= req_wdata;
                        end
                    end
                end
                READ: begin
                    if (!cap_we) begin
                        state     <= RESP;
                        rsp_valid <= 1'b1;
                        rsp_rdata <= load_data;
                        rsp_fault <= 1'b0;
                    end else begin
                        state     <= WRITE;
                        mem_memw  <= 1'b1;
                        mem_addr  <= {cap_addr[31:2], 2'b00};
                        mem_wdata <= merge_data;
                    end
                end
                WRITE: begin
                    state     <= RESP;
                    rsp_valid <= 1'b1;
                    rsp_rdata <= 32'd0;
                    rsp_fault <= 1'b0;
                end
                default: begin
                    state     <= IDLE;
                    req_ready <= 1'b1;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_load_store_unit.sv
// Bench for load_store_unit: directed vector table, random ops against a byte-array
// memory model, plus reset-in-flight and back-to-back request sequences.
module tb_load_store_unit;

    localparam logic [31:0] BASE  = 32'h1000;
    localparam int          WORDS = 1024;

    logic        clk = 1'b0;
    logic        reset;
    logic        req_valid;
    logic        req_ready;
    logic        req_we;
    logic [1:0]  req_size;
    logic        req_unsigned;
    logic [31:0] req_addr;
    logic [31:0] req_wdata;
    logic        rsp_valid;
    logic [31:0] rsp_rdata;
    logic        rsp_fault;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic        mem_memr;
    logic        mem_memw;
    logic [31:0] mem_rdata;

    load_store_unit #(.DMEM_BASE_ADDR(BASE), .DMEM_WORDS(WORDS)) dut (
        .clk(clk), .reset(reset),
        .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
        .req_size(req_size), .req_unsigned(req_unsigned),
        .req_addr(req_addr), .req_wdata(req_wdata),
        .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata), .rsp_fault(rsp_fault),
        .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_memr(mem_memr),
        .mem_memw(mem_memw), .mem_rdata(mem_rdata)
    );

    always #5 clk = ~clk;

    int errors = 0;
    int checks = 0;

    // memory seen by the DUT, and an independent byte-level reference copy
    logic [31:0] tb_mem  [WORDS];
    logic [7:0]  ref_mem [4*WORDS];

    always_comb begin
        mem_rdata = 32'hDEADBEEF;
        if (mem_addr >= BASE && mem_addr < BASE + 4*WORDS)
            mem_rdata = tb_mem[(mem_addr - BASE) >> 2];
    end

    always @(posedge clk) begin
        if (mem_memw === 1'b1 && mem_addr >= BASE && mem_addr < BASE + 4*WORDS)
            tb_mem[(mem_addr - BASE) >> 2] = mem_wdata;
    end

    bit          mon_en = 1'b0;
    int          memr_cnt = 0, memw_cnt = 0, rsp_cnt = 0;
    logic [31:0] last_memr_addr, last_memw_addr, last_memw_wdata;

    always @(negedge clk) begin
        if (mon_en) begin
            if (mem_memr) begin memr_cnt++; last_memr_addr = mem_addr; end
            if (mem_memw) begin
                memw_cnt++; last_memw_addr = mem_addr; last_memw_wdata = mem_wdata;
            end
            if (rsp_valid) rsp_cnt++;
            checks++;
            if ((mem_memr && mem_memw) ||
                (!mem_memr && !mem_memw && (mem_addr != 0 || mem_wdata != 0))) begin
                errors++;
                $display("FAIL mem_bus_idle: memr=%b memw=%b addr=%h wdata=%h, required no overlap and zero bus when idle",
                         mem_memr, mem_memw, mem_addr, mem_wdata);
            end
        end
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h, required %h", name, act, exp);
        end
    endtask

    task automatic set_word(input int idx, input logic [31:0] val);
        tb_mem[idx] = val;
        for (int i = 0; i < 4; i++) ref_mem[4*idx + i] = 8'(val >> (8*i));
    endtask

    function automatic logic [31:0] ref_word(input int idx);
        logic [31:0] w = 0;
        for (int i = 0; i < 4; i++) w |= 32'(ref_mem[4*idx + i]) << (8*i);
        return w;
    endfunction

    // Reference behaviour from the request rules; stores update ref_mem byte by byte
    task automatic ref_op(input logic we, input logic [1:0] size, input logic uns,
                          input logic [31:0] addr, input logic [31:0] wdata,
                          output logic fault, output logic [31:0] rdata, output int lat,
                          output int nr, output int nw, output logic [31:0] word);
        longint a = longint'(addr);
        int nb, off;
        fault = (size == 3) || (size == 1 && addr[0]) || (size == 2 && addr[1:0] != 0) ||
                (a < longint'(BASE)) || (a >= longint'(BASE) + 4*WORDS);
        rdata = 0; lat = 1; nr = 0; nw = 0; word = 0;
        if (!fault) begin
            nb  = 1 << size;
            off = int'(a - longint'(BASE));
            if (!we) begin
                for (int i = 0; i < nb; i++) rdata |= 32'(ref_mem[off + i]) << (8*i);
                if (!uns && nb < 4 && rdata[8*nb-1]) rdata |= 32'hFFFFFFFF << (8*nb);
                lat = 2; nr = 1;
            end else begin
                for (int i = 0; i < nb; i++) ref_mem[off + i] = 8'(wdata >> (8*i));
                lat = (nb == 4) ? 2 : 3;
                nr  = (nb == 4) ? 0 : 1;
                nw  = 1;
            end
            word = ref_word(off / 4);
        end
    endtask

    task automatic do_req(input string tag, input logic we, input logic [1:0] size,
                          input logic uns, input logic [31:0] addr, input logic [31:0] wdata,
                          output logic [31:0] got_rdata, output logic got_fault,
                          output int got_lat);
        logic        e_fault;
        logic [31:0] e_rdata, e_word;
        int          e_lat, e_nr, e_nw, r0, w0, n, lat;
        ref_op(we, size, uns, addr, wdata, e_fault, e_rdata, e_lat, e_nr, e_nw, e_word);
        r0 = memr_cnt; w0 = memw_cnt;
        @(negedge clk);
        n = 0;
        while (req_ready !== 1'b1 && n < 20) begin @(negedge clk); n++; end
        chk({tag, " ready"}, 32'(req_ready), 32'd1);
        req_valid = 1'b1; req_we = we; req_size = size; req_unsigned = uns;
        req_addr = addr; req_wdata = wdata;
        @(posedge clk);
        lat = 0;
        do begin
            @(negedge clk);
            if (lat == 0) req_valid = 1'b0;
            lat++;
        end while (rsp_valid !== 1'b1 && lat < 10);
        got_rdata = rsp_rdata; got_fault = rsp_fault; got_lat = lat;
        chk({tag, " latency"}, 32'(lat), 32'(e_lat));
        chk({tag, " fault"}, 32'(rsp_fault), 32'(e_fault));
        chk({tag, " rdata"}, rsp_rdata, e_rdata);
        chk({tag, " memr_cycles"}, 32'(memr_cnt - r0), 32'(e_nr));
        chk({tag, " memw_cycles"}, 32'(memw_cnt - w0), 32'(e_nw));
        if (e_nr != 0) chk({tag, " memr_addr"}, last_memr_addr, {addr[31:2], 2'b00});
        if (e_nw != 0) begin
            chk({tag, " memw_addr"}, last_memw_addr, {addr[31:2], 2'b00});
            chk({tag, " memw_wdata"}, last_memw_wdata, e_word);
        end
    endtask

    typedef struct {
        logic        we;
        logic [1:0]  size;
        logic        uns;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [31:0] exp_rdata;
        logic        exp_fault;
        int          exp_lat;
        logic [31:0] exp_wdata;
    } vec_t;

    vec_t vecs [16];

    initial begin : watchdog
        #300000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    initial begin
        logic [31:0] g_rdata;
        logic        g_fault;
        int          g_lat;
        logic [31:0] q_exp [$];
        int          rsp0;

        vecs[0]  = '{0, 2'b10, 0, 32'h1000, 32'h0,        32'h00000004, 0, 2, 32'h0};
        vecs[1]  = '{0, 2'b00, 0, 32'h1007, 32'h0,        32'hFFFFFF80, 0, 2, 32'h0};
        vecs[2]  = '{0, 2'b00, 1, 32'h1007, 32'h0,        32'h00000080, 0, 2, 32'h0};
        vecs[3]  = '{0, 2'b01, 0, 32'h1006, 32'h0,        32'hFFFF80FF, 0, 2, 32'h0};
        vecs[4]  = '{0, 2'b01, 0, 32'h1003, 32'h0,        32'h00000000, 1, 1, 32'h0};
        vecs[5]  = '{0, 2'b10, 0, 32'h2000, 32'h0,        32'h00000000, 1, 1, 32'h0};
        vecs[6]  = '{0, 2'b11, 0, 32'h1000, 32'h0,        32'h00000000, 1, 1, 32'h0};
        vecs[7]  = '{1, 2'b10, 0, 32'h1000, 32'h11223344, 32'h00000000, 0, 2, 32'h11223344};
        vecs[8]  = '{1, 2'b00, 0, 32'h1001, 32'h000000AB, 32'h00000000, 0, 3, 32'h1122AB44};
        vecs[9]  = '{0, 2'b10, 0, 32'h1000, 32'h0,        32'h1122AB44, 0, 2, 32'h0};
        vecs[10] = '{1, 2'b01, 0, 32'h1002, 32'h1234BEEF, 32'h00000000, 0, 3, 32'hBEEFAB44};
        vecs[11] = '{0, 2'b01, 1, 32'h1002, 32'h0,        32'h0000BEEF, 0, 2, 32'h0};
        vecs[12] = '{0, 2'b01, 0, 32'h1002, 32'h0,        32'hFFFFBEEF, 0, 2, 32'h0};
        vecs[13] = '{0, 2'b00, 0, 32'h1000, 32'h0,        32'h00000044, 0, 2, 32'h0};
        vecs[14] = '{0, 2'b00, 0, 32'h0FFF, 32'h0,        32'h00000000, 1, 1, 32'h0};
        vecs[15] = '{0, 2'b10, 0, 32'h1FFC, 32'h0,        32'hCAFEF00D, 0, 2, 32'h0};

        for (int i = 0; i < WORDS; i++) set_word(i, $urandom);
        set_word(0, 32'h00000004);
        set_word(1, 32'h80FF1234);
        set_word(WORDS - 1, 32'hCAFEF00D);

        reset = 1'b1; req_valid = 1'b0; req_we = 1'b0; req_size = 2'b00;
        req_unsigned = 1'b0; req_addr = 32'h0; req_wdata = 32'h0;
        repeat (3) @(negedge clk);
        chk("reset req_ready", 32'(req_ready), 32'd1);
        chk("reset rsp_valid", 32'(rsp_valid), 32'd0);
        chk("reset rsp_rdata", rsp_rdata, 32'd0);
        chk("reset rsp_fault", 32'(rsp_fault), 32'd0);
        chk("reset mem_ctl", {30'd0, mem_memr, mem_memw}, 32'd0);
        chk("reset mem_addr", mem_addr, 32'd0);
        reset = 1'b0;
        mon_en = 1'b1;
        @(negedge clk);
        chk("post_reset req_ready", 32'(req_ready), 32'd1);

        for (int i = 0; i < 16; i++) begin
            do_req($sformatf("vec%0d", i), vecs[i].we, vecs[i].size, vecs[i].uns,
                   vecs[i].addr, vecs[i].wdata, g_rdata, g_fault, g_lat);
            chk($sformatf("vec%0d table_rdata", i), g_rdata, vecs[i].exp_rdata);
            chk($sformatf("vec%0d table_fault", i), 32'(g_fault), 32'(vecs[i].exp_fault));
            chk($sformatf("vec%0d table_lat", i), 32'(g_lat), 32'(vecs[i].exp_lat));
            if (vecs[i].we)
                chk($sformatf("vec%0d table_wdata", i), last_memw_wdata, vecs[i].exp_wdata);
        end

        // reset while a byte store is in its READ cycle: no write, no response
        begin
            int w0, r0;
            @(negedge clk);
            w0 = memw_cnt; r0 = rsp_cnt;
            req_valid = 1'b1; req_we = 1'b1; req_size = 2'b00; req_unsigned = 1'b0;
            req_addr = 32'h1001; req_wdata = 32'h00000055;
            @(negedge clk);
            req_valid = 1'b0;
            chk("rst_inflight in_read", 32'(mem_memr), 32'd1);
            reset = 1'b1;
            @(negedge clk);
            chk("rst_inflight memr_cleared", 32'(mem_memr), 32'd0);
            chk("rst_inflight memw", 32'(mem_memw), 32'd0);
            reset = 1'b0;
            @(negedge clk);
            chk("rst_inflight ready", 32'(req_ready), 32'd1);
            repeat (3) @(negedge clk);
            chk("rst_inflight memw_cycles", 32'(memw_cnt - w0), 32'd0);
            chk("rst_inflight rsp_cycles", 32'(rsp_cnt - r0), 32'd0);
            chk("rst_inflight memory", tb_mem[0], ref_word(0));
        end

        // req_valid held with word loads: one accept every 3 cycles, responses in order
        begin
            logic        f;
            logic [31:0] rd, wd, a;
            int          lt, nr, nw;
            rsp0 = rsp_cnt;
            req_we = 1'b0; req_size = 2'b10; req_unsigned = 1'b0;
            for (int i = 0; i < 12; i++) begin
                @(negedge clk);
                chk($sformatf("b2b ready c%0d", i), 32'(req_ready), 32'((i % 3) == 0));
                chk($sformatf("b2b rsp_valid c%0d", i), 32'(rsp_valid), 32'((i % 3) == 2));
                if (rsp_valid) begin
                    if (q_exp.size() == 0) chk($sformatf("b2b extra_rsp c%0d", i), 32'd1, 32'd0);
                    else chk($sformatf("b2b rdata c%0d", i), rsp_rdata, q_exp.pop_front());
                end
                if ((i % 3) == 0) begin
                    a = BASE + 4 * $urandom_range(0, WORDS - 1);
                    ref_op(1'b0, 2'b10, 1'b0, a, 32'h0, f, rd, lt, nr, nw, wd);
                    q_exp.push_back(rd);
                    req_addr = a;
                    req_valid = 1'b1;
                end
            end
            @(negedge clk);
            req_valid = 1'b0;
            chk("b2b rsp_count", 32'(rsp_cnt - rsp0), 32'd4);
        end

        for (int n = 0; n < 60; n++) begin
            logic [31:0] a;
            int          r;
            r = $urandom_range(0, 9);
            if (r == 0)      a = 32'h2000 + $urandom_range(0, 255);
            else if (r == 1) a = BASE - 1 - $urandom_range(0, 15);
            else             a = BASE + $urandom_range(0, 4*WORDS - 1);
            do_req($sformatf("rnd%0d", n), 1'($urandom_range(0, 1)), 2'($urandom_range(0, 3)),
                   1'($urandom_range(0, 1)), a, $urandom, g_rdata, g_fault, g_lat);
        end

        for (int i = 0; i < WORDS; i++)
            if (tb_mem[i] !== ref_word(i))
                chk($sformatf("final_mem word%0d", i), tb_mem[i], ref_word(i));
        chk("final_mem word0", tb_mem[0], ref_word(0));

        @(negedge clk);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
